// File: rtl/johnson_pkg.sv
// Shared constants and width-generic helpers for Johnson (twisted-ring) sequence blocks.
package johnson_pkg;

   localparam logic DIR_UP    = 1'b0;
   localparam logic DIR_DOWN  = 1'b1;
   localparam int   MAX_WIDTH = 32;

   // Legal Johnson codes have at most one boundary between adjacent bits.
   function automatic logic johnson_legal(input logic [MAX_WIDTH-1:0] vec, input int width);
      int edges;
      edges = 0;
      for (int i = 0; i < MAX_WIDTH-1; i++)
         if ((i < width-1) && (vec[i] != vec[i+1]))
            edges++;
      return (edges <= 1);
   endfunction

   // Step index from population count; the LSB tells which half of the ring we are in.
   function automatic logic [6:0] johnson_phase(input logic [MAX_WIDTH-1:0] vec, input int width);
      int k;
      k = 0;
      for (int i = 0; i < MAX_WIDTH; i++)
         if ((i < width) && vec[i])
            k++;
      if (!vec[0])
         return 7'(k);
      else
         return 7'(2*width - k);
   endfunction

endpackage

// File: rtl/d_ff.sv
// Library D flip-flop cell with asynchronous active-high reset and set.
module d_ff (
   input  logic clk,
   input  logic rst,
   input  logic set,
   input  logic d,
   output logic q
);

   // Reset wins over set; otherwise capture d on the rising edge.
   always_ff @(posedge clk or posedge rst or posedge set) begin
      if (rst)
         q <= 1'b0;
      else if (set)
         q <= 1'b1;
      else
         q <= d;
   end

endmodule

// File: rtl/johnson_phase_decode.sv
// Combinational decode of a Johnson code into its step index and a legality flag.
module johnson_phase_decode #(
   parameter int WIDTH = 4,
   parameter int PW    = $clog2(2*WIDTH)
) (
   input  logic [WIDTH-1:0] vec,
   output logic [PW-1:0]    phase,
   output logic             illegal
);
   import johnson_pkg::*;

   // Phase is still computed for illegal codes so it never goes X.
   always_comb begin
      illegal = ~johnson_legal(MAX_WIDTH'(vec), WIDTH);
      phase   = PW'(johnson_phase(MAX_WIDTH'(vec), WIDTH));
   end

endmodule

// File: rtl/johnson_counter_param.sv
// Parametrised Johnson counter with enable, direction, load, phase decode, terminal count
// and illegal-state detection. Define JOHNSON_SELF_CORRECT_EN to force illegal states to 0.
module johnson_counter_param #(
   parameter  int WIDTH = 4,
   localparam int PW    = $clog2(2*WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] out,
   output logic [PW-1:0]    phase,
   output logic             tc,
   output logic             illegal
);
   import johnson_pkg::*;

   // Codes one step before the wrap back to zero in each direction.
   localparam logic [WIDTH-1:0] LAST_UP = WIDTH'(1);
   localparam logic [WIDTH-1:0] LAST_DN = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH-1:0] nxt;
   logic [WIDTH-1:0] up_step;
   logic [WIDTH-1:0] dn_step;

   assign up_step = {~out[0], out[WIDTH-1:1]};
   assign dn_step = {out[WIDTH-2:0], ~out[WIDTH-1]};

   // Next-state select: load beats correction, correction beats stepping, else hold.
   always_comb begin
      nxt = out;
      if (load)
         nxt = load_val;
`ifdef JOHNSON_SELF_CORRECT_EN
      else if (illegal)
         nxt = '0;
`endif
      else if (en)
         nxt = (dir == DIR_UP) ? up_step : dn_step;
   end

   // State register built from the shared d_ff cell; set is never used here.
   for (genvar g = 0; g < WIDTH; g++) begin : g_ff
      d_ff u_ff (
         .clk (clk),
         .rst (rst),
         .set (1'b0),
         .d   (nxt[g]),
         .q   (out[g])
      );
   end

   johnson_phase_decode #(.WIDTH(WIDTH), .PW(PW)) u_dec (
      .vec     (out),
      .phase   (phase),
      .illegal (illegal)
   );

   // Strobe only when the step that is about to happen lands on zero.
   always_comb begin
      tc = en & ~load & ~illegal &
           (((dir == DIR_UP)   && (out == LAST_UP)) ||
            ((dir == DIR_DOWN) && (out == LAST_DN)));
   end

endmodule

// File: tb/tb_johnson_counter_param.sv
// Directed bench for johnson_counter_param: vector table on WIDTH=4 plus width sweeps.
module tb_johnson_counter_param;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0, dir = 1'b0, load = 1'b0;
   logic [3:0] load_val = 4'h0;
   logic [3:0] out;
   logic [2:0] phase;
   logic       tc, illegal;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   johnson_counter_param #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
      .out(out), .phase(phase), .tc(tc), .illegal(illegal)
   );

   // Width-sweep instances, normalised onto 32-bit views for a generic task.
   logic        s_en[3], s_dir[3], s_load[3];
   logic [31:0] s_lv[3];
   logic [31:0] s_out[3];
   logic [7:0]  s_ph[3];
   logic        s_ill[3], s_tc[3];
   logic [1:0]  o2;  logic [1:0] ph2;
   logic [4:0]  o5;  logic [3:0] ph5;
   logic [7:0]  o8;  logic [3:0] ph8;

   johnson_counter_param #(.WIDTH(2)) dut2 (
      .clk(clk), .rst(rst), .en(s_en[0]), .dir(s_dir[0]), .load(s_load[0]),
      .load_val(s_lv[0][1:0]), .out(o2), .phase(ph2), .tc(s_tc[0]), .illegal(s_ill[0]));
   johnson_counter_param #(.WIDTH(5)) dut5 (
      .clk(clk), .rst(rst), .en(s_en[1]), .dir(s_dir[1]), .load(s_load[1]),
      .load_val(s_lv[1][4:0]), .out(o5), .phase(ph5), .tc(s_tc[1]), .illegal(s_ill[1]));
   johnson_counter_param #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .en(s_en[2]), .dir(s_dir[2]), .load(s_load[2]),
      .load_val(s_lv[2][7:0]), .out(o8), .phase(ph8), .tc(s_tc[2]), .illegal(s_ill[2]));

   assign s_out[0] = 32'(o2); assign s_ph[0] = 8'(ph2);
   assign s_out[1] = 32'(o5); assign s_ph[1] = 8'(ph5);
   assign s_out[2] = 32'(o8); assign s_ph[2] = 8'(ph8);

   typedef struct {
      logic       ld;
      logic [3:0] lv;
      logic       en;
      logic       dir;
      logic [3:0] o;
      logic [2:0] ph;
      logic       tc;
      logic       ill;
      logic       cp;   // compare phase (skipped for illegal codes)
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic ld, input logic [3:0] lv, input logic e, input logic d,
                               input logic [3:0] o, input logic [2:0] ph, input logic t,
                               input logic il, input logic cp);
      vec_t v;
      v.ld = ld; v.lv = lv; v.en = e; v.dir = d; v.o = o; v.ph = ph; v.tc = t; v.ill = il; v.cp = cp;
      return v;
   endfunction

   // Reference: position of v in the up sequence generated from zero, or -1 if absent.
   function automatic int seq_idx(input logic [31:0] v, input int w);
      logic [31:0] cur;
      logic [31:0] mask;
      cur  = '0;
      mask = (32'd1 << w) - 32'd1;
      for (int p = 0; p < 2*w; p++) begin
         if (cur == (v & mask)) return p;
         cur = ({31'd0, ~cur[0]} << (w-1)) | (cur >> 1);
      end
      return -1;
   endfunction

   task automatic step_main();
      @(posedge clk); #1;
   endtask

   task automatic sweep(input int idx, input int w);
      int seen[64];
      int nleg, p, n, tcs;
      logic ok;
      foreach (seen[i]) seen[i] = 0;
      nleg = 0;
      s_en[idx] = 1'b0; s_dir[idx] = 1'b0; s_load[idx] = 1'b1;
      for (int c = 0; c < (1 << w); c++) begin
         s_lv[idx] = 32'(c);
         @(posedge clk); #1;
         chk($sformatf("w%0d_load_%0h", w, c), s_out[idx], 32'(c));
         p = seq_idx(32'(c), w);
         chk($sformatf("w%0d_illegal_%0h", w, c), 32'(s_ill[idx]), (p < 0) ? 32'd1 : 32'd0);
         if (p >= 0) begin
            chk($sformatf("w%0d_phase_%0h", w, c), 32'(s_ph[idx]), 32'(p));
            nleg++;
            if (!$isunknown(s_ph[idx])) seen[s_ph[idx][5:0]]++;
         end else begin
            chk($sformatf("w%0d_phase_known_%0h", w, c), 32'($isunknown(s_ph[idx])), 32'd0);
         end
      end
      chk($sformatf("w%0d_legal_count", w), 32'(nleg), 32'(2*w));
      ok = 1'b1;
      for (int i = 0; i < 2*w; i++) if (seen[i] != 1) ok = 1'b0;
      chk($sformatf("w%0d_phase_bijection", w), 32'(ok), 32'd1);
      // Cycle length and one tc per wrap, both directions.
      for (int d = 0; d < 2; d++) begin
         s_load[idx] = 1'b1; s_lv[idx] = '0;
         @(posedge clk); #1;
         s_load[idx] = 1'b0; s_en[idx] = 1'b1; s_dir[idx] = d[0];
         n = 0; tcs = 0;
         do begin
            if (s_tc[idx]) tcs++;
            @(posedge clk); #1;
            n++;
         end while (s_out[idx] != 0 && n < 100);
         chk($sformatf("w%0d_len_dir%0d", w, d), 32'(n), 32'(2*w));
         chk($sformatf("w%0d_tc_dir%0d", w, d), 32'(tcs), 32'd1);
         s_en[idx] = 1'b0;
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         s_en[i] = 1'b0; s_dir[i] = 1'b0; s_load[i] = 1'b0; s_lv[i] = '0;
      end
      // Reset state, with en/dir active to show tc stays low.
      en = 1'b1; dir = 1'b1;
      #1;
      chk("reset_out", 32'(out), 32'h0);
      chk("reset_phase", 32'(phase), 32'h0);
      chk("reset_tc", 32'(tc), 32'h0);
      chk("reset_illegal", 32'(illegal), 32'h0);
      step_main();
      chk("reset_held_out", 32'(out), 32'h0);
      rst = 1'b0; en = 1'b0; dir = 1'b0;

      // Up sequence twice from zero.
      for (int r = 0; r < 2; r++) begin
         tbl.push_back(mk(0, 4'h0, 1, 0, 4'h8, 3'd1, 0, 0, 1));
         tbl.push_back(mk(0, 4'h0, 1, 0, 4'hC, 3'd2, 0, 0, 1));
         tbl.push_back(mk(0, 4'h0, 1, 0, 4'hE, 3'd3, 0, 0, 1));
         tbl.push_back(mk(0, 4'h0, 1, 0, 4'hF, 3'd4, 0, 0, 1));
         tbl.push_back(mk(0, 4'h0, 1, 0, 4'h7, 3'd5, 0, 0, 1));
         tbl.push_back(mk(0, 4'h0, 1, 0, 4'h3, 3'd6, 0, 0, 1));
         tbl.push_back(mk(0, 4'h0, 1, 0, 4'h1, 3'd7, 1, 0, 1));
         tbl.push_back(mk(0, 4'h0, 1, 0, 4'h0, 3'd0, 0, 0, 1));
      end
      // Up to 1110, then reverse.
      tbl.push_back(mk(0, 4'h0, 1, 0, 4'h8, 3'd1, 0, 0, 1));
      tbl.push_back(mk(0, 4'h0, 1, 0, 4'hC, 3'd2, 0, 0, 1));
      tbl.push_back(mk(0, 4'h0, 1, 0, 4'hE, 3'd3, 0, 0, 1));
      tbl.push_back(mk(0, 4'h0, 1, 1, 4'hC, 3'd2, 0, 0, 1));
      tbl.push_back(mk(0, 4'h0, 1, 1, 4'h8, 3'd1, 1, 0, 1));
      tbl.push_back(mk(0, 4'h0, 1, 1, 4'h0, 3'd0, 0, 0, 1));
      tbl.push_back(mk(0, 4'h0, 1, 1, 4'h1, 3'd7, 0, 0, 1));
      // Hold at 0001 with dir=up: tc gated by en.
      tbl.push_back(mk(0, 4'h0, 0, 0, 4'h1, 3'd7, 0, 0, 1));
      // Load priority: tc gated by load.
      tbl.push_back(mk(1, 4'h1, 1, 0, 4'h1, 3'd7, 0, 0, 1));
      tbl.push_back(mk(1, 4'h7, 1, 0, 4'h7, 3'd5, 0, 0, 1));
      for (int h = 0; h < 5; h++)
         tbl.push_back(mk(0, 4'h0, 0, 1, 4'h7, 3'd5, 0, 0, 1));
      tbl.push_back(mk(1, 4'h5, 1, 0, 4'h5, 3'd0, 0, 1, 0));

      foreach (tbl[i]) begin
         load = tbl[i].ld; load_val = tbl[i].lv; en = tbl[i].en; dir = tbl[i].dir;
         step_main();
         chk($sformatf("row%0d_out", i), 32'(out), 32'(tbl[i].o));
         if (tbl[i].cp) chk($sformatf("row%0d_phase", i), 32'(phase), 32'(tbl[i].ph));
         chk($sformatf("row%0d_tc", i), 32'(tc), 32'(tbl[i].tc));
         chk($sformatf("row%0d_illegal", i), 32'(illegal), 32'(tbl[i].ill));
      end

      // Illegal handling from 0101 with en=1, dir=up.
      load = 1'b0; en = 1'b1; dir = 1'b0;
      step_main();
`ifdef JOHNSON_SELF_CORRECT_EN
      chk("fix_out", 32'(out), 32'h0);
      chk("fix_illegal", 32'(illegal), 32'h0);
      chk("fix_phase", 32'(phase), 32'h0);
`else
      chk("orbit1_out", 32'(out), 32'h2);
      chk("orbit1_illegal", 32'(illegal), 32'h1);
      chk("orbit1_tc", 32'(tc), 32'h0);
      step_main();
      chk("orbit2_out", 32'(out), 32'h9);
      chk("orbit2_illegal", 32'(illegal), 32'h1);
`endif
      // Illegal state with en low.
      load = 1'b1; load_val = 4'h5;
      step_main();
      load = 1'b0; en = 1'b0;
      step_main();
`ifdef JOHNSON_SELF_CORRECT_EN
      chk("fix_noen_out", 32'(out), 32'h0);
`else
      chk("hold_illegal_out", 32'(out), 32'h5);
      chk("hold_illegal_flag", 32'(illegal), 32'h1);
`endif

      // Asynchronous reset mid-count at 1110.
      load = 1'b1; load_val = 4'hE;
      step_main();
      chk("pre_rst_out", 32'(out), 32'hE);
      load = 1'b0; en = 1'b1; dir = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("async_rst_out", 32'(out), 32'h0);
      chk("async_rst_phase", 32'(phase), 32'h0);
      chk("async_rst_tc", 32'(tc), 32'h0);
      step_main();
      chk("rst_hold_out", 32'(out), 32'h0);
      rst = 1'b0;
      step_main();
      chk("first_step_out", 32'(out), 32'h8);
      en = 1'b0;

      sweep(0, 2);
      sweep(1, 5);
      sweep(2, 8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
